// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RV32 definitions used by the instruction queue, the format decoder
// and the immediate generator.
//   - OP_*    : 7-bit major opcodes (inst[6:0])
//   - FMT_*   : bit positions inside the one-hot instruction-format vector
//   - FMT_W   : width of that one-hot vector
// -----------------------------------------------------------------------------
package rv_pkg;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int unsigned FMT_R = 0;
   localparam int unsigned FMT_I = 1;
   localparam int unsigned FMT_S = 2;
   localparam int unsigned FMT_B = 3;
   localparam int unsigned FMT_U = 4;
   localparam int unsigned FMT_J = 5;
   localparam int unsigned FMT_W = 6;

endpackage

// File: rtl/inst_format_decode.sv
// -----------------------------------------------------------------------------
// inst_format_decode
// Combinational classifier: maps an instruction word to its one-hot encoding
// format. Unknown opcodes (including compressed encodings, inst[1:0] != 2'b11)
// give an all-zero format and raise o_illegal.
// Ports:
//   i_inst     in   32  instruction word
//   o_format   out  6   one-hot [0]R [1]I [2]S [3]B [4]U [5]J
//   o_illegal  out  1   opcode not recognised
// -----------------------------------------------------------------------------
module inst_format_decode
   import rv_pkg::*;
(
   input  logic [31:0]      i_inst,
   output logic [FMT_W-1:0] o_format,
   output logic             o_illegal
);

   always_comb begin
      o_format  = '0;
      o_illegal = 1'b0;
      case (i_inst[6:0])
         OP_REG:                                         o_format[FMT_R] = 1'b1;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  o_format[FMT_I] = 1'b1;
         OP_STORE:                                       o_format[FMT_S] = 1'b1;
         OP_BRANCH:                                      o_format[FMT_B] = 1'b1;
         OP_LUI, OP_AUIPC:                               o_format[FMT_U] = 1'b1;
         OP_JAL:                                         o_format[FMT_J] = 1'b1;
         default:                                        o_illegal       = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Small FIFO between fetch and decode. Each word is classified at enqueue and
// the format is stored alongside the word and PC, so the head outputs come
// straight from registers (no combinational path from i_inst).
// Parameters:
//   DEPTH          entries, power of two, >= 2
// Ports:
//   i_clk          in   1   clock
//   i_rst          in   1   synchronous active-high reset
//   i_inst_valid   in   1   fetch presents a word
//   o_inst_ready   out  1   queue can accept
//   i_inst         in   32  fetched word
//   i_pc           in   32  PC of i_inst
//   i_flush        in   1   discard all entries
//   o_valid        out  1   head entry valid
//   i_ready        in   1   decode consumes head
//   o_inst         out  32  head word
//   o_pc           out  32  head PC
//   o_format       out  6   head one-hot format
//   o_illegal      out  1   head opcode unrecognised
// -----------------------------------------------------------------------------
module inst_queue
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inst_valid,
   output logic             o_inst_ready,
   input  logic [31:0]      i_inst,
   input  logic [31:0]      i_pc,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_inst,
   output logic [31:0]      o_pc,
   output logic [FMT_W-1:0] o_format,
   output logic             o_illegal
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [CW-1:0]    r_count;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;

   logic [31:0]      r_inst    [DEPTH];
   logic [31:0]      r_pc      [DEPTH];
   logic [FMT_W-1:0] r_format  [DEPTH];
   logic             r_illegal [DEPTH];

   logic [FMT_W-1:0] w_format;
   logic             w_illegal;
   logic             w_push;
   logic             w_pop;

   inst_format_decode u_decode (
      .i_inst    (i_inst),
      .o_format  (w_format),
      .o_illegal (w_illegal)
   );

   assign o_inst_ready = ~i_rst & (r_count != CW'(DEPTH));
   assign o_valid      = (r_count != '0);

   assign w_push = i_inst_valid & o_inst_ready & ~i_flush;
   assign w_pop  = o_valid & i_ready & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: it is only observed while o_valid is high.
   // w_push already excludes reset because o_inst_ready is gated by i_rst.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_inst[r_wr_ptr]    <= i_inst;
         r_pc[r_wr_ptr]      <= i_pc;
         r_format[r_wr_ptr]  <= w_format;
         r_illegal[r_wr_ptr] <= w_illegal;
      end
   end

   assign o_inst    = r_inst[r_rd_ptr];
   assign o_pc      = r_pc[r_rd_ptr];
   assign o_format  = r_format[r_rd_ptr];
   assign o_illegal = r_illegal[r_rd_ptr];

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

   localparam int unsigned DEPTH = 2;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_inst_valid = 1'b0;
   logic        o_inst_ready;
   logic [31:0] i_inst = '0;
   logic [31:0] i_pc = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic [5:0]  o_format;
   logic        o_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [5:0]  fmt;
      logic        ill;
   } entry_t;

   entry_t mq[$];

   always #5 i_clk = ~i_clk;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_inst_valid (i_inst_valid),
      .o_inst_ready (o_inst_ready),
      .i_inst       (i_inst),
      .i_pc         (i_pc),
      .i_flush      (i_flush),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_inst       (o_inst),
      .o_pc         (o_pc),
      .o_format     (o_format),
      .o_illegal    (o_illegal)
   );

   // Reference classification straight from the opcode table: {illegal, format}
   function automatic logic [6:0] ref_decode(input logic [31:0] w);
      logic [6:0] op;
      op = w[6:0];
      if (op == 7'h33)                                   return 7'b0_000001;
      if (op == 7'h13 || op == 7'h03 || op == 7'h67 ||
          op == 7'h73 || op == 7'h0F)                    return 7'b0_000010;
      if (op == 7'h23)                                   return 7'b0_000100;
      if (op == 7'h63)                                   return 7'b0_001000;
      if (op == 7'h37 || op == 7'h17)                    return 7'b0_010000;
      if (op == 7'h6F)                                   return 7'b0_100000;
      return 7'b1_000000;
   endfunction

   // Apply one cycle of inputs (called at negedge), advance the queue model,
   // and return at the following negedge.
   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                        input logic rdy, input logic fl, input logic rst);
      entry_t e;
      logic [6:0] d;
      bit m_push, m_pop;
      i_inst_valid = v;
      i_inst       = w;
      i_pc         = p;
      i_ready      = rdy;
      i_flush      = fl;
      i_rst        = rst;
      if (rst || fl) begin
         mq.delete();
      end else begin
         m_push = v && (mq.size() < DEPTH);
         m_pop  = (mq.size() > 0) && rdy;
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            d = ref_decode(w);
            e.inst = w; e.pc = p; e.fmt = d[5:0]; e.ill = d[6];
            mq.push_back(e);
         end
      end
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      drive(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      n_tests++;
      if (o_inst_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", o_inst_ready); end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_inst_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", o_inst_ready); end
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b exp=0", o_valid); end
   endtask

   task automatic test_formats();
      logic [31:0] words [7] = '{32'h002081B3, 32'h00500093, 32'h00112623, 32'h00000463,
                                 32'h123450B7, 32'h0000006F, 32'h00000000};
      logic [5:0]  fmts  [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                                 6'b010000, 6'b100000, 6'b000000};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, words[i], 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
         n_tests++;
         if (o_valid !== 1'b1 || o_inst !== words[i] || o_pc !== 32'h1000 + 32'(i * 4))
            begin n_fail++; $display("FAIL fmt_head[%0d] got v=%b inst=%h pc=%h exp v=1 inst=%h", i, o_valid, o_inst, o_pc, words[i]); end
         n_tests++;
         if (o_format !== fmts[i]) begin n_fail++; $display("FAIL fmt_format[%0d] got=%b exp=%b", i, o_format, fmts[i]); end
         n_tests++;
         if (o_illegal !== (i == 6)) begin n_fail++; $display("FAIL fmt_illegal[%0d] got=%b exp=%b", i, o_illegal, (i == 6)); end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL fmt_drain got=%b exp=0", o_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a = 32'h00A00093, b = 32'h00B00113, c = 32'h00C00193;
      drive(1'b1, a, 32'h200, 1'b0, 1'b0, 1'b0);
      drive(1'b1, b, 32'h204, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_inst_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", o_inst_ready); end
      n_tests++;
      if (o_inst !== a) begin n_fail++; $display("FAIL full_head got=%h exp=%h", o_inst, a); end
      drive(1'b1, c, 32'h208, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_inst !== a || o_pc !== 32'h200 || o_valid !== 1'b1 || o_inst_ready !== 1'b0)
         begin n_fail++; $display("FAIL hold_head got=%h pc=%h v=%b rdy=%b exp=%h pc=200 v=1 rdy=0", o_inst, o_pc, o_valid, o_inst_ready, a); end
      drive(1'b1, c, 32'h208, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_inst !== b) begin n_fail++; $display("FAIL order_b got=%h exp=%h", o_inst, b); end
      drive(1'b1, c, 32'h208, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_inst !== c || o_valid !== 1'b1) begin n_fail++; $display("FAIL order_c got=%h v=%b exp=%h", o_inst, o_valid, c); end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL order_drain got=%b exp=0", o_valid); end
   endtask

   task automatic test_flush();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0 || o_inst_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got v=%b rdy=%b exp v=0 rdy=1", o_valid, o_inst_ready); end
      drive(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h00300093, 32'h308, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0 || o_inst_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", o_valid, o_inst_ready); end
      drive(1'b1, 32'h0000006F, 32'h400, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_inst !== 32'h0000006F || o_pc !== 32'h400 || o_format !== 6'b100000)
         begin n_fail++; $display("FAIL flush_next got=%h pc=%h fmt=%b exp=0000006f pc=400 fmt=100000", o_inst, o_pc, o_format); end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_sole got=%b exp=0", o_valid); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h00200093, 32'h504, 1'b0, 1'b0, 1'b0);
      i_rst = 1'b1;
      #1;
      n_tests++;
      if (o_inst_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_during got=%b exp=0", o_inst_ready); end
      drive(1'b1, 32'h00300093, 32'h508, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (o_valid !== 1'b0 || o_inst_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold got v=%b rdy=%b exp 0 0", o_valid, o_inst_ready); end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0 || o_inst_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after got v=%b rdy=%b exp v=0 rdy=1", o_valid, o_inst_ready); end
   endtask

   task automatic test_random();
      logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                               7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      logic [31:0] w;
      logic [6:0]  op;
      int unsigned k;
      entry_t h;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         n_tests++;
         if (o_valid !== (mq.size() > 0) || o_inst_ready !== (!i_rst && mq.size() < DEPTH))
            begin n_fail++; $display("FAIL rnd_flags[%0d] got v=%b rdy=%b exp v=%b rdy=%b", cyc, o_valid, o_inst_ready, (mq.size() > 0), (!i_rst && mq.size() < DEPTH)); end
         if (mq.size() > 0) begin
            h = mq[0];
            n_tests++;
            if (o_inst !== h.inst || o_pc !== h.pc || o_format !== h.fmt || o_illegal !== h.ill)
               begin n_fail++; $display("FAIL rnd_head[%0d] got %h/%h/%b/%b exp %h/%h/%b/%b", cyc, o_inst, o_pc, o_format, o_illegal, h.inst, h.pc, h.fmt, h.ill); end
         end
         k = $urandom_range(0, 13);
         op = (k < 11) ? ops[k] : 7'($urandom);
         w = {25'($urandom), op};
         drive(1'($urandom_range(0, 3) != 0), w, $urandom, 1'($urandom_range(0, 2) != 0),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
      end
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_formats();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
